l2_cache_test: RTL and testbench

- Unified second-level cache between the L1 cache (32-bit word interface) and main memory (64-bit line interface).
- Direct-mapped, write-back, write-allocate, 64-bit (two-word) lines.
- Stalls the L1 cache while a request is serviced.
- Keeps hit and miss statistics counters, readable as `cache_hit_counter` and `cache_miss_counter`.

---
 rtl/l2_cache_test_if.sv | 30 +++
 rtl/l2_cache_test.sv | 146 ++++++++++++++
 tb/tb_l2_cache_test.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_test_if.sv
// l2_cache_test_if: L1 and memory handshake signals of the L2 cache.
//   slave  : cache side (receives L1 requests and memory done strobes,
//            drives stall, memory requests and statistics counters)
//   master : environment side (L1 cache plus main memory)
// The 32-bit and 64-bit tristate data buses stay plain inout ports on
// the cache module, so the resolved nets live at the instantiating level.
interface l2_cache_test_if #(parameter int CNT_W = 32);
    logic             stb;
    logic             weL1L2;
    logic             addrstbL1L2;
    logic [31:0]      addrL1L2;
    logic             stall;
    logic             weL2MEM;
    logic             addrstbL2MEM;
    logic [31:0]      addrL2MEM;
    logic [CNT_W-1:0] cache_hit_counter;
    logic [CNT_W-1:0] cache_miss_counter;

    modport slave (
        input  stb, weL1L2, addrstbL1L2, addrL1L2,
        output stall, weL2MEM, addrstbL2MEM, addrL2MEM,
        output cache_hit_counter, cache_miss_counter
    );

    modport master (
        output stb, weL1L2, addrstbL1L2, addrL1L2,
        input  stall, weL2MEM, addrstbL2MEM, addrL2MEM,
        input  cache_hit_counter, cache_miss_counter
    );
endinterface

// File: rtl/l2_cache_test.sv
// l2_cache_test: direct-mapped, write-back, write-allocate L2 cache with
// 64-bit lines between a 32-bit L1 word interface and a 64-bit memory.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   bus       : request/stall/memory-request/counter signals (slave modport)
//   dataL1L2  : L1 data bus; L1 drives on write strobe, cache drives on
//               the RESPOND cycle of a read
//   dataL2MEM : memory data bus; cache drives during writeback, memory
//               drives in the stb cycle of a fill
module l2_cache_test #(
    parameter int INDEX_BITS = 8,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    l2_cache_test_if.slave    bus,
    inout  wire  [31:0]       dataL1L2,
    inout  wire  [63:0]       dataL2MEM
);
    localparam int TAG_W = 29 - INDEX_BITS;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [63:0]      data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  word_sel;
    logic [63:0]           line;
    logic [63:0]           line_wdata;
    logic                  line_we;
    logic                  hit;
    logic                  unused_bits;

    function automatic logic [63:0] merge_word(input logic [63:0] l, input logic sel,
                                               input logic [31:0] w);
        return sel ? {w, l[31:0]} : {l[63:32], w};
    endfunction

    assign idx         = addr_q[2+INDEX_BITS:3];
    assign req_tag     = addr_q[31:3+INDEX_BITS];
    assign word_sel    = addr_q[2];
    assign unused_bits = ^addr_q[1:0];
    assign line        = data_mem[idx];
    assign hit         = valid_q[idx] && (tag_mem[idx] == req_tag);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        line_we    = 1'b0;
        line_wdata = line;
        case (state_q)
            IDLE: if (bus.addrstbL1L2) begin
                addr_d  = bus.addrL1L2;
                we_d    = bus.weL1L2;
                wdata_d = bus.weL1L2 ? dataL1L2 : wdata_q;
                state_d = LOOKUP;
            end
            LOOKUP: if (hit) begin
                hit_d   = hit_q + CNT_W'(1);
                state_d = RESPOND;
                if (we_q) begin
                    line_we      = 1'b1;
                    line_wdata   = merge_word(line, word_sel, wdata_q);
                    dirty_d[idx] = 1'b1;
                end
            end else begin
                miss_d  = miss_q + CNT_W'(1);
                // only a valid dirty victim needs to go back to memory first
                state_d = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : FILL_REQ;
            end
            WB_REQ:   state_d = WB_WAIT;
            WB_WAIT:  state_d = bus.stb ? FILL_REQ : WB_WAIT;
            FILL_REQ: state_d = FILL_WAIT;
            FILL_WAIT: if (bus.stb) begin
                // write-allocate: the L1 word overrides the fetched word
                line_we      = 1'b1;
                line_wdata   = we_q ? merge_word(dataL2MEM, word_sel, wdata_q) : dataL2MEM;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = we_q;
                state_d      = RESPOND;
            end
            RESPOND:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // line storage needs no reset: valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[idx] <= line_wdata;
            tag_mem[idx]  <= req_tag;
        end
    end

    assign bus.stall              = !(state_q == IDLE || state_q == RESPOND);
    assign bus.addrstbL2MEM       = (state_q == WB_REQ) || (state_q == FILL_REQ);
    assign bus.weL2MEM            = (state_q == WB_REQ);
    assign bus.addrL2MEM          = (state_q == WB_REQ)   ? {tag_mem[idx], idx, 3'b000} :
                                    (state_q == FILL_REQ) ? {req_tag, idx, 3'b000} : '0;
    assign bus.cache_hit_counter  = hit_q;
    assign bus.cache_miss_counter = miss_q;

    assign dataL2MEM = (state_q == WB_REQ || state_q == WB_WAIT) ? line : 'z;
    assign dataL1L2  = (state_q == RESPOND && !we_q) ?
                       (word_sel ? line[63:32] : line[31:0]) : 'z;
endmodule

// File: tb/tb_l2_cache_test.sv
// tb_l2_cache_test: directed self-checking bench for l2_cache_test.
module tb_l2_cache_test;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wire  [31:0] dataL1L2;
    wire  [63:0] dataL2MEM;
    logic        l1_drv = 1'b0;
    logic [31:0] l1_data = '0;
    logic        mem_drv = 1'b0;
    logic [63:0] mem_data = '0;
    assign dataL1L2  = l1_drv  ? l1_data  : 'z;
    assign dataL2MEM = mem_drv ? mem_data : 'z;

    l2_cache_test_if #(.CNT_W(32)) bus();

    l2_cache_test #(.INDEX_BITS(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .dataL1L2(dataL1L2), .dataL2MEM(dataL2MEM)
    );

    int passed = 0;
    int total = 0;
    logic        ok, mwe, saw;
    logic [31:0] maddr, rdata;
    logic [63:0] mdata;
    int          cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic l1_req(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addrstbL1L2 = 1'b1;
        bus.weL1L2 = we;
        bus.addrL1L2 = a;
        l1_drv = we;
        l1_data = d;
        @(negedge clk);
        bus.addrstbL1L2 = 1'b0;
        bus.weL1L2 = 1'b0;
        l1_drv = 1'b0;
    endtask

    task automatic wait_mem(output logic f, output logic we, output logic [31:0] a,
                            output logic [63:0] d);
        f = 1'b0; we = 1'b0; a = '0; d = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.addrstbL2MEM) begin
                f = 1'b1; we = bus.weL2MEM; a = bus.addrL2MEM; d = dataL2MEM;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic mem_done(input logic fill, input logic [63:0] d);
        @(negedge clk);
        bus.stb = 1'b1;
        mem_drv = fill;
        mem_data = d;
        @(negedge clk);
        bus.stb = 1'b0;
        mem_drv = 1'b0;
    endtask

    task automatic wait_resp(output logic f, output logic [31:0] d, output int n,
                             output logic s);
        f = 1'b0; d = '0; n = 0; s = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.addrstbL2MEM) s = 1'b1;
            if (!bus.stall) begin
                f = 1'b1; d = dataL1L2;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bus.stb = 1'b0;
        bus.weL1L2 = 1'b0;
        bus.addrstbL1L2 = 1'b0;
        bus.addrL1L2 = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", bus.stall, 0);
        check("rst_addrstb", bus.addrstbL2MEM, 0);
        check("rst_we", bus.weL2MEM, 0);
        check("rst_addr", bus.addrL2MEM, 0);
        check("rst_hit", bus.cache_hit_counter, 0);
        check("rst_miss", bus.cache_miss_counter, 0);
        reset = 1'b0;

        // cold read miss of 0x0: single fill, low word returned
        l1_req(1'b0, 32'h0, 32'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("m1_seen", ok, 1);
        check("m1_we", mwe, 0);
        check("m1_addr", maddr, 32'h0);
        mem_done(1'b1, 64'h1111_1111_2222_2222);
        wait_resp(ok, rdata, cyc, saw);
        check("r1_ok", ok, 1);
        check("r1_data", rdata, 32'h2222_2222);
        check("r1_hit", bus.cache_hit_counter, 0);
        check("r1_miss", bus.cache_miss_counter, 1);

        // read hit on the upper word: one stall cycle, no memory traffic
        l1_req(1'b0, 32'h4, 32'h0);
        check("r2_stall", bus.stall, 1);
        wait_resp(ok, rdata, cyc, saw);
        check("r2_ok", ok, 1);
        check("r2_cycles", cyc, 1);
        check("r2_data", rdata, 32'h1111_1111);
        check("r2_nomem", saw, 0);
        check("r2_hit", bus.cache_hit_counter, 1);

        // write hit dirties line 0
        l1_req(1'b1, 32'h4, 32'hDEAD_BEEF);
        wait_resp(ok, rdata, cyc, saw);
        check("w3_ok", ok, 1);
        check("w3_cycles", cyc, 1);
        check("w3_nomem", saw, 0);
        check("w3_hit", bus.cache_hit_counter, 2);
        check("w3_miss", bus.cache_miss_counter, 1);

        // conflict miss on index 0: writeback of merged line, then fill
        l1_req(1'b0, 32'h800, 32'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("wb4_seen", ok, 1);
        check("wb4_we", mwe, 1);
        check("wb4_addr", maddr, 32'h0);
        check("wb4_data", mdata, 64'hDEAD_BEEF_2222_2222);
        mem_done(1'b0, 64'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("f4_seen", ok, 1);
        check("f4_we", mwe, 0);
        check("f4_addr", maddr, 32'h800);
        mem_done(1'b1, 64'hAAAA_AAAA_BBBB_BBBB);
        wait_resp(ok, rdata, cyc, saw);
        check("r4_data", rdata, 32'hBBBB_BBBB);
        check("r4_miss", bus.cache_miss_counter, 2);

        // write miss on invalid line 2: fill only, word merged
        l1_req(1'b1, 32'h1010, 32'h1234_5678);
        wait_mem(ok, mwe, maddr, mdata);
        check("f5_seen", ok, 1);
        check("f5_we", mwe, 0);
        check("f5_addr", maddr, 32'h1010);
        mem_done(1'b1, 64'h5555_5555_6666_6666);
        wait_resp(ok, rdata, cyc, saw);
        check("w5_ok", ok, 1);
        check("w5_miss", bus.cache_miss_counter, 3);
        l1_req(1'b0, 32'h1010, 32'h0);
        wait_resp(ok, rdata, cyc, saw);
        check("r5_lo", rdata, 32'h1234_5678);
        l1_req(1'b0, 32'h1014, 32'h0);
        wait_resp(ok, rdata, cyc, saw);
        check("r5_hi", rdata, 32'h5555_5555);
        check("r5_hit", bus.cache_hit_counter, 4);

        // conflict on line 2 proves it is dirty; then reset mid-fill
        l1_req(1'b0, 32'h810, 32'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("wb6_we", mwe, 1);
        check("wb6_addr", maddr, 32'h1010);
        check("wb6_data", mdata, 64'h5555_5555_1234_5678);
        check("wb6_miss", bus.cache_miss_counter, 4);
        mem_done(1'b0, 64'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("f6_addr", maddr, 32'h810);
        @(negedge clk);
        check("f6_stall", bus.stall, 1);
        #2 reset = 1'b1;
        #1;
        check("ab_stall", bus.stall, 0);
        check("ab_hit", bus.cache_hit_counter, 0);
        check("ab_miss", bus.cache_miss_counter, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_done(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ab_idle_stall", bus.stall, 0);
        check("ab_idle_strb", bus.addrstbL2MEM, 0);

        // after reset the cache is empty again
        l1_req(1'b0, 32'h0, 32'h0);
        wait_mem(ok, mwe, maddr, mdata);
        check("m7_seen", ok, 1);
        check("m7_we", mwe, 0);
        check("m7_addr", maddr, 32'h0);
        mem_done(1'b1, 64'h7777_7777_8888_8888);
        wait_resp(ok, rdata, cyc, saw);
        check("r7_data", rdata, 32'h8888_8888);
        check("r7_miss", bus.cache_miss_counter, 1);
        check("r7_hit", bus.cache_hit_counter, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
